// File: rtl/digit_entry_ctrl_pkg.sv
// Shared types and constants for the trig calculator operand-entry / display block.
package trig_disp_pkg;

    localparam int unsigned NDIG = 4;
    localparam int unsigned OPW  = 14;
    localparam int unsigned BCDW = 4;
    localparam int unsigned SEGW = 8;

    typedef logic [BCDW-1:0] bcd_t;

    typedef enum logic [1:0] {
        EDIT = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        SHOW = 2'd3
    } state_t;

    // Four BCD digits, d1 is the most significant (occupies [15:12]).
    typedef struct packed {
        bcd_t d1;
        bcd_t d2;
        bcd_t d3;
        bcd_t d4;
    } digits_t;

    // Active-low segment codes: bit7=dp, bit6..bit0 = a,b,c,d,e,f,g.
    localparam logic [SEGW-1:0] SEG_BLANK = 8'hFF;
    localparam logic [SEGW-1:0] SEG_DASH  = 8'hFE;
    localparam logic [SEGW-1:0] SEG_0     = 8'h81;
    localparam logic [SEGW-1:0] SEG_1     = 8'hCF;
    localparam logic [SEGW-1:0] SEG_2     = 8'h92;
    localparam logic [SEGW-1:0] SEG_3     = 8'h86;
    localparam logic [SEGW-1:0] SEG_4     = 8'hCC;
    localparam logic [SEGW-1:0] SEG_5     = 8'hA4;
    localparam logic [SEGW-1:0] SEG_6     = 8'hA0;
    localparam logic [SEGW-1:0] SEG_7     = 8'h8F;
    localparam logic [SEGW-1:0] SEG_8     = 8'h80;
    localparam logic [SEGW-1:0] SEG_9     = 8'h84;

    // BCD to binary using shift-add constant multiplies (1000 = 1024-16-8, 100 = 64+32+4, 10 = 8+2).
    function automatic logic [OPW-1:0] bcd4_to_bin(input digits_t d);
        logic [OPW-1:0] th;
        logic [OPW-1:0] hu;
        logic [OPW-1:0] te;
        logic [OPW-1:0] un;
        th = OPW'(d.d1);
        hu = OPW'(d.d2);
        te = OPW'(d.d3);
        un = OPW'(d.d4);
        return (th << 10) - (th << 4) - (th << 3)
             + (hu << 6) + (hu << 5) + (hu << 2)
             + (te << 3) + (te << 1)
             + un;
    endfunction

endpackage

// File: rtl/digit_entry_ctrl_if.sv
// Operand request / result return handshake between entry controller and compute unit.
interface digit_entry_ctrl_if;
    import trig_disp_pkg::*;

    logic           calc_req;
    logic [OPW-1:0] operand;
    logic           calc_ack;
    logic           calc_done;
    digits_t        result_bcd;

    // Entry controller side
    modport master (
        output calc_req,
        output operand,
        input  calc_ack,
        input  calc_done,
        input  result_bcd
    );

    // Compute unit side
    modport slave (
        input  calc_req,
        input  operand,
        output calc_ack,
        output calc_done,
        output result_bcd
    );

endinterface

// File: rtl/digit_entry_ctrl_seg.sv
// One-digit 7-segment decoder with blanking; non-decimal codes show a dash.
module bcd_to_seg
    import trig_disp_pkg::*;
(
    input  bcd_t            bcd_i,
    input  logic            blank_i,
    output logic [SEGW-1:0] seg_o
);

    // Decode digit to active-low segment pattern
    always_comb begin
        seg_o = SEG_DASH;
        if (blank_i) begin
            seg_o = SEG_BLANK;
        end else begin
            case (bcd_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/digit_entry_ctrl.sv
// Operand entry sequencer and 4-digit display driver for the trig calculator.
// Optional feature macro: BACKSPACE_EN adds the back_p key (delete LSD).
module digit_entry_ctrl
    import trig_disp_pkg::*;
(
    input  logic                clknew,
    input  logic                rst_n,
    input  logic                inc_p,
    input  logic                shift_p,
    input  logic                go_p,
`ifdef BACKSPACE_EN
    input  logic                back_p,
`endif
    digit_entry_ctrl_if.master  calc,
    output logic [SEGW-1:0]     seg1,
    output logic [SEGW-1:0]     seg2,
    output logic [SEGW-1:0]     seg3,
    output logic [SEGW-1:0]     seg4,
    output logic                busy
);

    state_t         state_q;
    digits_t        digits_q;
    digits_t        digits_d;
    logic [OPW-1:0] operand_q;
    logic           calc_req_q;
    logic           busy_q;

    bcd_t            dig_a   [NDIG];
    logic            blank_a [NDIG];
    logic [SEGW-1:0] code_a  [NDIG];
    logic            dash_c;

    // Next value of the digit register: key edits in EDIT, clear from SHOW, result capture in WAIT
    always_comb begin
        digits_d = digits_q;
        case (state_q)
            EDIT: begin
                if (!go_p) begin
`ifdef BACKSPACE_EN
                    if (back_p) begin
                        digits_d.d1 = '0;
                        digits_d.d2 = digits_q.d1;
                        digits_d.d3 = digits_q.d2;
                        digits_d.d4 = digits_q.d3;
                    end else
`endif
                    if (shift_p) begin
                        // A non-zero MSD would fall off the left edge, so the shift is refused
                        if (digits_q.d1 == '0) begin
                            digits_d.d1 = digits_q.d2;
                            digits_d.d2 = digits_q.d3;
                            digits_d.d3 = digits_q.d4;
                            digits_d.d4 = '0;
                        end
                    end else if (inc_p) begin
                        digits_d.d4 = (digits_q.d4 == 4'd9) ? 4'd0 : digits_q.d4 + 4'd1;
                    end
                end
            end
            WAIT: begin
                if (calc.calc_done) begin
                    digits_d = calc.result_bcd;
                end
            end
            SHOW: begin
                if (!go_p && (inc_p || shift_p)) begin
                    digits_d = '0;
                end
            end
            default: begin
                digits_d = digits_q;
            end
        endcase
    end

    // Control FSM with registered handshake and status outputs
    always_ff @(posedge clknew or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EDIT;
            digits_q   <= '0;
            operand_q  <= '0;
            calc_req_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            digits_q <= digits_d;
            case (state_q)
                EDIT: begin
                    if (go_p) begin
                        operand_q  <= bcd4_to_bin(digits_q);
                        state_q    <= REQ;
                        calc_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                REQ: begin
                    if (calc.calc_ack) begin
                        state_q    <= WAIT;
                        calc_req_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (calc.calc_done) begin
                        state_q <= SHOW;
                        busy_q  <= 1'b0;
                    end
                end
                SHOW: begin
                    // Re-request reuses the operand already held in operand_q
                    if (go_p) begin
                        state_q    <= REQ;
                        calc_req_q <= 1'b1;
                        busy_q     <= 1'b1;
                    end else if (inc_p || shift_p) begin
                        state_q <= EDIT;
                    end
                end
                default: begin
                    state_q <= EDIT;
                end
            endcase
        end
    end

    assign calc.calc_req = calc_req_q;
    assign calc.operand  = operand_q;
    assign busy          = busy_q;

    // Digit fan-out and leading-zero blanking; the LSD is never blanked
    always_comb begin
        dig_a[0]   = digits_q.d1;
        dig_a[1]   = digits_q.d2;
        dig_a[2]   = digits_q.d3;
        dig_a[3]   = digits_q.d4;
        blank_a[0] = (digits_q.d1 == '0);
        blank_a[1] = (digits_q.d1 == '0) && (digits_q.d2 == '0);
        blank_a[2] = (digits_q.d1 == '0) && (digits_q.d2 == '0) && (digits_q.d3 == '0);
        blank_a[3] = 1'b0;
    end

    for (genvar gi = 0; gi < int'(NDIG); gi++) begin : g_seg
        bcd_to_seg u_seg (
            .bcd_i   (dig_a[gi]),
            .blank_i (blank_a[gi]),
            .seg_o   (code_a[gi])
        );
    end

    // Busy pattern overrides the digits while a computation is outstanding
    assign dash_c = (state_q == REQ) || (state_q == WAIT);
    assign seg1   = dash_c ? SEG_DASH : code_a[0];
    assign seg2   = dash_c ? SEG_DASH : code_a[1];
    assign seg3   = dash_c ? SEG_DASH : code_a[2];
    assign seg4   = dash_c ? SEG_DASH : code_a[3];

endmodule
